writeback_stage: RTL and testbench

//  Final GPU pipeline stage; transmitter end of the Decode writeback interface.

---
 rtl/writeback_stage.sv | 124 ++++++++++++
 tb/tb_writeback_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: buffers retired MEM results in a small FIFO and drives Decode's RF/CC/PC write ports.
module writeback_stage #(
  parameter int REG_WIDTH     = 16,
  parameter int VREG_WIDTH    = 64,
  parameter int VREG_ID_WIDTH = 6,
  parameter int PC_WIDTH      = 16,
  parameter int DEPTH         = 2
) (
  input  logic                       I_CLOCK,
  input  logic                       I_RESET_N,
  input  logic                       I_MW_Valid,
  output logic                       O_MW_Ready,
  input  logic [3:0]                 I_MW_DestRegIdx,
  input  logic                       I_MW_DestWrite,
  input  logic [VREG_ID_WIDTH-1:0]   I_MW_DestVRegIdx,
  input  logic                       I_MW_DestVWrite,
  input  logic [REG_WIDTH-1:0]       I_MW_Data,
  input  logic [VREG_WIDTH-1:0]      I_MW_VecData,
  input  logic                       I_MW_CCWEn,
  input  logic                       I_MW_BrTaken,
  input  logic [PC_WIDTH-1:0]        I_MW_BrPC,
  input  logic                       I_WB_Hold,
  output logic [3:0]                 O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]       O_WriteBackData,
  output logic                       O_RegWEn,
  output logic [VREG_ID_WIDTH-1:0]   O_WriteBackVRegIdx,
  output logic [VREG_WIDTH-1:0]      O_VecDestValue,
  output logic                       O_VRegWEn,
  output logic [2:0]                 O_CCValue,
  output logic                       O_CCWEn,
  output logic [PC_WIDTH-1:0]        O_WriteBackPC,
  output logic                       O_WriteBackPCEn,
  output logic [15:0]                O_PendingRegMask,
  output logic [$clog2(DEPTH):0]     O_Count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]               r_ridx  [DEPTH];
  logic [VREG_ID_WIDTH-1:0] r_vidx  [DEPTH];
  logic [REG_WIDTH-1:0]     r_data  [DEPTH];
  logic [VREG_WIDTH-1:0]    r_vdata [DEPTH];
  logic [PC_WIDTH-1:0]      r_brpc  [DEPTH];
  logic [DEPTH-1:0]         r_dw, r_vw, r_ccw, r_br;
  logic [DEPTH-1:0]         r_pw;
  logic [PW-1:0]            r_wptr, r_rptr;
  logic [CW-1:0]            r_count;

  logic                 w_push, w_pop, w_n, w_z;
  logic [REG_WIDTH-1:0] w_hd_data;
  logic [DEPTH-1:0]     w_pw_next;
  logic [15:0]          w_mask_next;

  assign O_MW_Ready = r_count < CW'(DEPTH);
  assign O_Count    = r_count;
  assign w_push     = I_MW_Valid & O_MW_Ready;
  assign w_pop      = (r_count != '0) & ~I_WB_Hold;
  assign w_hd_data  = r_data[r_rptr];
  assign w_n        = w_hd_data[REG_WIDTH-1];
  assign w_z        = w_hd_data == '0;

  // Mask reflects the post-edge FIFO contents plus the entry about to be driven.
  always_comb begin
    w_pw_next = r_pw;
    if (w_pop) w_pw_next[r_rptr] = 1'b0;
    if (w_push) w_pw_next[r_wptr] = I_MW_DestWrite;
    w_mask_next = (w_pop && r_dw[r_rptr]) ? (16'd1 << r_ridx[r_rptr]) : 16'd0;
    for (int i = 0; i < DEPTH; i++)
      if (w_pw_next[i])
        w_mask_next = w_mask_next | (16'd1 << ((w_push && r_wptr == PW'(i)) ? I_MW_DestRegIdx : r_ridx[i]));
  end

  always_ff @(posedge I_CLOCK) begin
    if (w_push) begin
      r_ridx[r_wptr]  <= I_MW_DestRegIdx;
      r_vidx[r_wptr]  <= I_MW_DestVRegIdx;
      r_data[r_wptr]  <= I_MW_Data;
      r_vdata[r_wptr] <= I_MW_VecData;
      r_brpc[r_wptr]  <= I_MW_BrPC;
      r_dw[r_wptr]    <= I_MW_DestWrite;
      r_vw[r_wptr]    <= I_MW_DestVWrite;
      r_ccw[r_wptr]   <= I_MW_CCWEn;
      r_br[r_wptr]    <= I_MW_BrTaken;
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_wptr             <= '0;
      r_rptr             <= '0;
      r_count            <= '0;
      r_pw               <= '0;
      O_PendingRegMask   <= '0;
      O_WriteBackRegIdx  <= '0;
      O_WriteBackData    <= '0;
      O_RegWEn           <= 1'b0;
      O_WriteBackVRegIdx <= '0;
      O_VecDestValue     <= '0;
      O_VRegWEn          <= 1'b0;
      O_CCValue          <= '0;
      O_CCWEn            <= 1'b0;
      O_WriteBackPC      <= '0;
      O_WriteBackPCEn    <= 1'b0;
    end else begin
      r_pw             <= w_pw_next;
      O_PendingRegMask <= w_mask_next;
      r_count          <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      O_RegWEn        <= w_pop & r_dw[r_rptr];
      O_VRegWEn       <= w_pop & r_vw[r_rptr];
      O_CCWEn         <= w_pop & r_ccw[r_rptr];
      O_WriteBackPCEn <= w_pop & r_br[r_rptr];
      if (w_pop) begin
        r_rptr             <= r_rptr + 1'b1;
        O_WriteBackRegIdx  <= r_ridx[r_rptr];
        O_WriteBackData    <= w_hd_data;
        O_WriteBackVRegIdx <= r_vidx[r_rptr];
        O_VecDestValue     <= r_vdata[r_rptr];
        O_WriteBackPC      <= r_brpc[r_rptr];
        if (r_ccw[r_rptr]) O_CCValue <= {w_n, w_z, ~w_n & ~w_z};
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table-driven cycle vectors plus hand sequences for vector writes and reset aborts.
module tb_writeback_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid, ready, dw, vw, ccw, br, hold;
  logic [3:0]  ri;
  logic [5:0]  vi;
  logic [15:0] d, pc;
  logic [63:0] vd;
  logic [3:0]  o_idx;
  logic [15:0] o_data, o_pc, o_mask;
  logic        o_we, o_vwe, o_ccwe, o_pce;
  logic [5:0]  o_vidx;
  logic [63:0] o_vd;
  logic [2:0]  o_cc;
  logic [1:0]  o_cnt;
  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .I_MW_Valid(valid), .O_MW_Ready(ready),
    .I_MW_DestRegIdx(ri), .I_MW_DestWrite(dw), .I_MW_DestVRegIdx(vi), .I_MW_DestVWrite(vw),
    .I_MW_Data(d), .I_MW_VecData(vd), .I_MW_CCWEn(ccw), .I_MW_BrTaken(br), .I_MW_BrPC(pc),
    .I_WB_Hold(hold), .O_WriteBackRegIdx(o_idx), .O_WriteBackData(o_data), .O_RegWEn(o_we),
    .O_WriteBackVRegIdx(o_vidx), .O_VecDestValue(o_vd), .O_VRegWEn(o_vwe), .O_CCValue(o_cc),
    .O_CCWEn(o_ccwe), .O_WriteBackPC(o_pc), .O_WriteBackPCEn(o_pce),
    .O_PendingRegMask(o_mask), .O_Count(o_cnt)
  );

  typedef struct {
    logic v; logic [3:0] ri; logic dw; logic [15:0] d; logic ccw; logic br; logic [15:0] pc; logic hold;
    logic e_we; logic [3:0] e_idx; logic [15:0] e_data; logic e_ccwe; logic [2:0] e_cc;
    logic e_pce; logic [15:0] e_pc; logic [1:0] e_cnt; logic e_rdy; logic [15:0] e_mask;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(int v, int r, int w, int dd, int c, int b, int p, int h,
                              int we, int idx, int dat, int cwe, int cc, int pce, int epc,
                              int cnt, int rdy, int msk);
    vec_t t;
    t.v = 1'(v); t.ri = 4'(r); t.dw = 1'(w); t.d = 16'(dd); t.ccw = 1'(c); t.br = 1'(b);
    t.pc = 16'(p); t.hold = 1'(h); t.e_we = 1'(we); t.e_idx = 4'(idx); t.e_data = 16'(dat);
    t.e_ccwe = 1'(cwe); t.e_cc = 3'(cc); t.e_pce = 1'(pce); t.e_pc = 16'(epc);
    t.e_cnt = 2'(cnt); t.e_rdy = 1'(rdy); t.e_mask = 16'(msk);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; ri = 0; dw = 0; vi = 0; vw = 0; d = 0; vd = 0; ccw = 0; br = 0; pc = 0; hold = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " regwen"}, 64'(o_we), 64'd0);
    chk({tag, " vregwen"}, 64'(o_vwe), 64'd0);
    chk({tag, " ccwen"}, 64'(o_ccwe), 64'd0);
    chk({tag, " pcen"}, 64'(o_pce), 64'd0);
    chk({tag, " count"}, 64'(o_cnt), 64'd0);
    chk({tag, " ready"}, 64'(ready), 64'd1);
    chk({tag, " mask"}, 64'(o_mask), 64'd0);
    chk({tag, " idx"}, 64'(o_idx), 64'd0);
    chk({tag, " data"}, 64'(o_data), 64'd0);
    chk({tag, " cc"}, 64'(o_cc), 64'd0);
  endtask

  initial begin
    // v ri dw d ccw br pc hold | we idx data ccwe cc pce pc cnt rdy mask
    tbl[0]  = mk(1,3,1,'h8001,1,0,0,0,     0,0,'h0000,0,3'b000,0,0,    1,1,'h0008);
    tbl[1]  = mk(0,0,0,0,0,0,0,0,          1,3,'h8001,1,3'b100,0,0,    0,1,'h0008);
    tbl[2]  = mk(1,0,1,'h0000,1,0,0,0,     0,3,'h8001,0,3'b100,0,0,    1,1,'h0001);
    tbl[3]  = mk(1,1,1,'h0005,0,0,0,0,     1,0,'h0000,1,3'b010,0,0,    1,1,'h0003);
    tbl[4]  = mk(0,0,0,0,0,0,0,0,          1,1,'h0005,0,3'b010,0,0,    0,1,'h0002);
    tbl[5]  = mk(0,0,0,0,0,0,0,0,          0,1,'h0005,0,3'b010,0,0,    0,1,'h0000);
    tbl[6]  = mk(1,4,1,'h1111,0,0,0,1,     0,1,'h0005,0,3'b010,0,0,    1,1,'h0010);
    tbl[7]  = mk(1,5,1,'h2222,0,0,0,1,     0,1,'h0005,0,3'b010,0,0,    2,0,'h0030);
    tbl[8]  = mk(1,6,1,'h3333,0,0,0,1,     0,1,'h0005,0,3'b010,0,0,    2,0,'h0030);
    tbl[9]  = mk(1,6,1,'h3333,0,0,0,0,     1,4,'h1111,0,3'b010,0,0,    1,1,'h0030);
    tbl[10] = mk(1,6,1,'h3333,0,0,0,0,     1,5,'h2222,0,3'b010,0,0,    1,1,'h0060);
    tbl[11] = mk(0,0,0,0,0,0,0,0,          1,6,'h3333,0,3'b010,0,0,    0,1,'h0040);
    tbl[12] = mk(0,0,0,0,0,0,0,0,          0,6,'h3333,0,3'b010,0,0,    0,1,'h0000);
    tbl[13] = mk(1,0,0,'h0000,0,1,'h40,0,  0,6,'h3333,0,3'b010,0,0,    1,1,'h0000);
    tbl[14] = mk(0,0,0,0,0,0,0,0,          0,0,'h0000,0,3'b010,1,'h40, 0,1,'h0000);
    tbl[15] = mk(0,0,0,0,0,0,0,0,          0,0,'h0000,0,3'b010,0,'h40, 0,1,'h0000);

    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("por");
    rst_n = 1;
    tick();

    for (int i = 0; i < 16; i++) begin
      valid = tbl[i].v; ri = tbl[i].ri; dw = tbl[i].dw; d = tbl[i].d; ccw = tbl[i].ccw;
      br = tbl[i].br; pc = tbl[i].pc; hold = tbl[i].hold;
      tick();
      chk($sformatf("v%0d regwen", i), 64'(o_we), 64'(tbl[i].e_we));
      chk($sformatf("v%0d idx", i), 64'(o_idx), 64'(tbl[i].e_idx));
      chk($sformatf("v%0d data", i), 64'(o_data), 64'(tbl[i].e_data));
      chk($sformatf("v%0d ccwen", i), 64'(o_ccwe), 64'(tbl[i].e_ccwe));
      chk($sformatf("v%0d cc", i), 64'(o_cc), 64'(tbl[i].e_cc));
      chk($sformatf("v%0d pcen", i), 64'(o_pce), 64'(tbl[i].e_pce));
      chk($sformatf("v%0d pc", i), 64'(o_pc), 64'(tbl[i].e_pc));
      chk($sformatf("v%0d count", i), 64'(o_cnt), 64'(tbl[i].e_cnt));
      chk($sformatf("v%0d ready", i), 64'(ready), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d mask", i), 64'(o_mask), 64'(tbl[i].e_mask));
      chk($sformatf("v%0d vregwen", i), 64'(o_vwe), 64'd0);
    end

    idle_inputs();
    valid = 1; vi = 9; vw = 1; vd = 64'h0001_0002_0003_0004;
    tick();
    idle_inputs();
    chk("vec queued count", 64'(o_cnt), 64'd1);
    chk("vec queued vregwen", 64'(o_vwe), 64'd0);
    tick();
    chk("vec vregwen", 64'(o_vwe), 64'd1);
    chk("vec vidx", 64'(o_vidx), 64'd9);
    chk("vec data", o_vd, 64'h0001_0002_0003_0004);
    chk("vec regwen", 64'(o_we), 64'd0);
    tick();
    chk("vec vregwen drop", 64'(o_vwe), 64'd0);

    hold = 1; valid = 1; ri = 2; dw = 1; d = 16'h00aa;
    tick();
    ri = 7; d = 16'h0077;
    tick();
    chk("pre-reset full count", 64'(o_cnt), 64'd2);
    valid = 0; hold = 0;
    tick();
    chk("pre-reset regwen", 64'(o_we), 64'd1);
    chk("pre-reset idx", 64'(o_idx), 64'd2);
    chk("pre-reset mask", 64'(o_mask), 64'h0084);
    #2 rst_n = 0;
    #1;
    chk_reset_state("mid-cycle");
    @(posedge clk);
    #1 rst_n = 1;
    idle_inputs();
    repeat (3) begin
      tick();
      chk("post-reset regwen", 64'(o_we), 64'd0);
      chk("post-reset count", 64'(o_cnt), 64'd0);
    end

    hold = 1; valid = 1; vi = 5; vw = 1; vd = 64'h0001_0002_0003_0004;
    tick();
    valid = 0;
    chk("vabort queued", 64'(o_cnt), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("vabort count", 64'(o_cnt), 64'd0);
    hold = 0;
    @(posedge clk);
    #1 rst_n = 1;
    repeat (4) begin
      tick();
      chk("vabort vregwen", 64'(o_vwe), 64'd0);
      chk("vabort count idle", 64'(o_cnt), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
